pico_scan_ctrl: RTL and testbench

PicoBus-mapped controller that sequences one subject-scan pass through the comparator datapath.
- Host writes query, length and start over PicoBus.
- FSM fetches subject words one at a time from the subject buffer and issues each with the query to the comparator.
- Counts hits and reports busy/done/abort status back over PicoBus.
- Sits between the PicoBus slave fabric and the scan datapath (subject buffer + comparators).

---
 rtl/pico_scan_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_pico_scan_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pico_scan_ctrl.sv
// PicoBus register front-end and scan sequencer for the subject buffer / comparator datapath.
// Optional build macro SCAN_IRQ_EN: CTRL[2] irq enable (STATUS[3]) and the done_irq pulse.
module pico_scan_ctrl #(
    parameter logic [31:0] ADDR_BASE = 32'h100,
    parameter int          LEN_W     = 16,
    parameter int          HIT_W     = 32
) (
    input  logic              PicoClk,
    input  logic              PicoRst_n,
    input  logic [31:0]       PicoAddr,
    input  logic [127:0]      PicoDataIn,
    input  logic              PicoRd,
    input  logic              PicoWr,
    output logic [127:0]      PicoDataOut,
    output logic              subj_rd_en,
    output logic [LEN_W-1:0]  subj_rd_addr,
    input  logic [127:0]      subj_rd_data,
    input  logic              subj_rd_valid,
    output logic [127:0]      cmp_query,
    output logic [127:0]      cmp_subject,
    output logic              cmp_valid,
    input  logic              cmp_result_valid,
    input  logic              cmp_hit,
    output logic              done_irq
);

    // state   | meaning
    // IDLE    | waiting for start; status holds last scan result
    // REQ     | one-cycle subject fetch request for word idx
    // WAIT    | waiting for subject buffer data
    // ISSUE   | one-cycle comparator issue of latched subject word
    // DRAIN   | all words issued, waiting for outstanding results
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [127:0]      query;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_inc;
    logic [LEN_W-1:0]  issued;
    logic [HIT_W-1:0]  hits;
    logic [LEN_W:0]    outstanding;
    logic              done;
    logic              done_nxt;
    logic              aborted;
    logic              aborted_nxt;
    logic              irq_en;
    logic [127:0]      rd_data;

    logic sel_ctrl, sel_query, sel_len, sel_status;
    logic wr_ctrl, start_req, abort_req, idle_start;
    logic busy, len_zero, out_zero, result_acc;

    assign sel_ctrl   = (PicoAddr == ADDR_BASE);
    assign sel_query  = (PicoAddr == ADDR_BASE + 32'h10);
    assign sel_len    = (PicoAddr == ADDR_BASE + 32'h20);
    assign sel_status = (PicoAddr == ADDR_BASE + 32'h30);

    // abort has priority over start when both bits arrive in one write
    assign wr_ctrl    = PicoWr & sel_ctrl;
    assign abort_req  = wr_ctrl & PicoDataIn[1];
    assign start_req  = wr_ctrl & PicoDataIn[0] & ~PicoDataIn[1];

    assign busy       = (state != S_IDLE);
    assign idle_start = start_req & ~busy;
    assign len_zero   = (len == '0);
    assign out_zero   = (outstanding == '0);
    assign idx_inc    = idx + LEN_W'(1);
    // results arriving with nothing outstanding (e.g. after abort) are dropped
    assign result_acc = cmp_result_valid & busy & ~out_zero;

    assign cmp_query    = query;
    assign subj_rd_addr = idx;

    always_ff @(posedge PicoClk or negedge PicoRst_n) begin
        if (!PicoRst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (idle_start && !len_zero) state_nxt = S_REQ;
            S_REQ:   state_nxt = S_WAIT;
            S_WAIT:  if (subj_rd_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (idx_inc == len) ? S_DRAIN : S_REQ;
            S_DRAIN: if (out_zero) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_req && busy) state_nxt = S_IDLE;
    end

    always_comb begin
        subj_rd_en = 1'b0;
        cmp_valid  = 1'b0;
        case (state)
            S_REQ:   subj_rd_en = 1'b1;
            S_ISSUE: cmp_valid  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        done_nxt    = done;
        aborted_nxt = aborted;
        if (abort_req) begin
            done_nxt    = 1'b1;
            aborted_nxt = 1'b1;
        end else if (idle_start) begin
            done_nxt = len_zero;
            if (!len_zero) aborted_nxt = 1'b0;
        end else if (state == S_DRAIN && out_zero) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge PicoClk or negedge PicoRst_n) begin
        if (!PicoRst_n) begin
            query       <= '0;
            len         <= '0;
            idx         <= '0;
            issued      <= '0;
            hits        <= '0;
            outstanding <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            cmp_subject <= '0;
        end else begin
            done    <= done_nxt;
            aborted <= aborted_nxt;
            if (PicoWr && sel_query && !busy) query <= PicoDataIn;
            if (PicoWr && sel_len && !busy) len <= PicoDataIn[LEN_W-1:0];

            if (idle_start && !len_zero) begin
                idx    <= '0;
                issued <= '0;
                hits   <= '0;
            end else begin
                if (cmp_valid) begin
                    idx    <= idx_inc;
                    issued <= issued + LEN_W'(1);
                end
                if (result_acc && cmp_hit && hits != '1) hits <= hits + HIT_W'(1);
            end

            if (state == S_WAIT && subj_rd_valid) cmp_subject <= subj_rd_data;

            if (abort_req) begin
                outstanding <= '0;
            end else if (cmp_valid && !result_acc) begin
                outstanding <= outstanding + (LEN_W+1)'(1);
            end else if (!cmp_valid && result_acc) begin
                outstanding <= outstanding - (LEN_W+1)'(1);
            end
        end
    end

`ifdef SCAN_IRQ_EN
    logic irq_en_nxt;
    assign irq_en_nxt = wr_ctrl ? PicoDataIn[2] : irq_en;

    // registered pulse lands in the same cycle the done flag first reads 1
    always_ff @(posedge PicoClk or negedge PicoRst_n) begin
        if (!PicoRst_n) begin
            irq_en   <= 1'b0;
            done_irq <= 1'b0;
        end else begin
            irq_en   <= irq_en_nxt;
            done_irq <= done_nxt & ~done & irq_en_nxt;
        end
    end
`else
    assign irq_en   = 1'b0;
    assign done_irq = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        if (sel_query) begin
            rd_data = query;
        end else if (sel_len) begin
            rd_data[LEN_W-1:0] = len;
        end else if (sel_status) begin
            rd_data[0]             = busy;
            rd_data[1]             = done;
            rd_data[2]             = aborted;
            rd_data[3]             = irq_en;
            rd_data[32 +: HIT_W]   = hits;
            rd_data[64 +: LEN_W]   = issued;
        end
    end

    // shared bus: drive zero except the cycle after a matching read
    always_ff @(posedge PicoClk or negedge PicoRst_n) begin
        if (!PicoRst_n) begin
            PicoDataOut <= '0;
        end else begin
            PicoDataOut <= PicoRd ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_pico_scan_ctrl.sv
// Scoreboard bench for pico_scan_ctrl: bus reads, subject fetches and comparator issues are
// pushed as expectations by the stimulus thread and popped by a negedge monitor.
module tb_pico_scan_ctrl;

    localparam logic [31:0] A_CTRL  = 32'h100;
    localparam logic [31:0] A_QUERY = 32'h110;
    localparam logic [31:0] A_LEN   = 32'h120;
    localparam logic [31:0] A_STAT  = 32'h130;
`ifdef SCAN_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic          PicoClk;
    logic          PicoRst_n;
    logic [31:0]   PicoAddr;
    logic [127:0]  PicoDataIn;
    logic          PicoRd;
    logic          PicoWr;
    logic [127:0]  PicoDataOut;
    logic          subj_rd_en;
    logic [15:0]   subj_rd_addr;
    logic [127:0]  subj_rd_data;
    logic          subj_rd_valid;
    logic [127:0]  cmp_query;
    logic [127:0]  cmp_subject;
    logic          cmp_valid;
    logic          cmp_result_valid;
    logic          cmp_hit;
    logic          done_irq;

    pico_scan_ctrl dut (
        .PicoClk          (PicoClk),
        .PicoRst_n        (PicoRst_n),
        .PicoAddr         (PicoAddr),
        .PicoDataIn       (PicoDataIn),
        .PicoRd           (PicoRd),
        .PicoWr           (PicoWr),
        .PicoDataOut      (PicoDataOut),
        .subj_rd_en       (subj_rd_en),
        .subj_rd_addr     (subj_rd_addr),
        .subj_rd_data     (subj_rd_data),
        .subj_rd_valid    (subj_rd_valid),
        .cmp_query        (cmp_query),
        .cmp_subject      (cmp_subject),
        .cmp_valid        (cmp_valid),
        .cmp_result_valid (cmp_result_valid),
        .cmp_hit          (cmp_hit),
        .done_irq         (done_irq)
    );

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_rd[$];
    logic [15:0]  exp_fetch[$];
    logic [127:0] exp_issue[$];
    logic [127:0] cur_query = '0;

    logic [7:0]   hit_pat  = '0;
    int           res_idx  = 0;
    int           inj_cnt  = 0;
    int           cmp_seen = 0;
    int           irq_cnt  = 0;
    int           irq_long = 0;

    logic [1:0]   sb_v;
    logic [15:0]  sb_a [2];
    logic [2:0]   cp_v;

    initial PicoClk = 1'b0;
    always #5 PicoClk = ~PicoClk;

    function automatic logic [127:0] subj_word(input logic [15:0] a);
        return {4{16'hBEEF, a}};
    endfunction

    function automatic logic [127:0] stat(input logic b, input logic d, input logic ab,
                                          input logic ie, input logic [31:0] h,
                                          input logic [15:0] n);
        logic [127:0] v;
        v = '0;
        v[0] = b;
        v[1] = d;
        v[2] = ab;
        v[3] = ie;
        v[63:32] = h;
        v[79:64] = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [127:0] d);
        @(posedge PicoClk); #1;
        PicoAddr = a; PicoDataIn = d; PicoWr = 1'b1;
        @(posedge PicoClk); #1;
        PicoAddr = '0; PicoDataIn = '0; PicoWr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [127:0] exp);
        @(posedge PicoClk); #1;
        PicoAddr = a; PicoRd = 1'b1;
        exp_rd.push_back(exp);
        @(posedge PicoClk); #1;
        PicoAddr = '0; PicoRd = 1'b0;
    endtask

    task automatic expect_scan(input int nfetch, input int nissue);
        for (int i = 0; i < nfetch; i++) exp_fetch.push_back(16'(i));
        for (int i = 0; i < nissue; i++) exp_issue.push_back(subj_word(16'(i)));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge PicoClk);
        #1;
    endtask

    // subject buffer: fixed 2-cycle latency
    initial begin
        subj_rd_valid = 1'b0;
        subj_rd_data  = '0;
        sb_v = '0;
        sb_a[0] = '0;
        sb_a[1] = '0;
        forever begin
            @(posedge PicoClk); #1;
            subj_rd_valid = sb_v[1];
            subj_rd_data  = sb_v[1] ? subj_word(sb_a[1]) : '0;
            sb_v[1] = sb_v[0];
            sb_a[1] = sb_a[0];
            sb_v[0] = subj_rd_en;
            sb_a[0] = subj_rd_addr;
        end
    end

    // comparator: 3-cycle result latency, hit flag from hit_pat, plus injected stray results
    initial begin
        cmp_result_valid = 1'b0;
        cmp_hit = 1'b0;
        cp_v = '0;
        forever begin
            @(posedge PicoClk); #1;
            if (cp_v[2]) begin
                cmp_result_valid = 1'b1;
                cmp_hit = hit_pat[res_idx];
                res_idx++;
            end else if (inj_cnt > 0) begin
                cmp_result_valid = 1'b1;
                cmp_hit = 1'b1;
                inj_cnt--;
            end else begin
                cmp_result_valid = 1'b0;
                cmp_hit = 1'b0;
            end
            cp_v = {cp_v[1:0], cmp_valid};
            if (cmp_valid) cmp_seen++;
        end
    end

    // monitor
    initial begin
        logic prev_rd;
        logic prev_irq;
        prev_rd = 1'b0;
        prev_irq = 1'b0;
        forever begin
            @(negedge PicoClk);
            if (prev_rd) begin
                if (exp_rd.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected: got %h expected no read data", PicoDataOut);
                end else begin
                    check("rd_data", PicoDataOut, exp_rd.pop_front());
                end
            end else begin
                check("bus_idle_zero", PicoDataOut, '0);
            end
            prev_rd = PicoRd;
            if (subj_rd_en) begin
                if (exp_fetch.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL fetch_unexpected: got addr %0d expected none", subj_rd_addr);
                end else begin
                    check("fetch_addr", subj_rd_addr, exp_fetch.pop_front());
                end
            end
            if (cmp_valid) begin
                check("issue_query", cmp_query, cur_query);
                if (exp_issue.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL issue_unexpected: got %h expected none", cmp_subject);
                end else begin
                    check("issue_subject", cmp_subject, exp_issue.pop_front());
                end
            end
            if (done_irq) begin
                irq_cnt++;
                if (prev_irq) irq_long++;
            end
            prev_irq = done_irq;
        end
    end

    initial begin
        int i;
        PicoRst_n  = 1'b0;
        PicoAddr   = '0;
        PicoDataIn = '0;
        PicoRd     = 1'b0;
        PicoWr     = 1'b0;
        idle_cycles(4);
        PicoRst_n = 1'b1;
        idle_cycles(2);

        // reset state
        check("reset_cmp_query", cmp_query, '0);
        check("reset_cmp_subject", cmp_subject, '0);
        bus_read(A_STAT, '0);
        bus_read(A_QUERY, '0);
        bus_read(32'h140, '0);
        bus_read(A_CTRL, '0);

        // LEN==0 start: done only, no fetch or issue
        bus_write(A_CTRL, 128'h1);
        bus_read(A_STAT, stat(0, 1, 0, 0, 0, 0));
        idle_cycles(10);

        // normal 4-word scan, hits on second and fourth result
        cur_query = {16{8'hA5}};
        bus_write(A_QUERY, cur_query);
        bus_write(A_LEN, 128'd4);
        bus_read(A_LEN, 128'd4);
        bus_read(A_QUERY, cur_query);
        hit_pat = 8'b0000_1010;
        res_idx = 0;
        cmp_seen = 0;
        expect_scan(4, 4);
        bus_write(A_CTRL, 128'h1);
        bus_read(A_STAT, stat(1, 0, 0, 0, 0, 0));
        idle_cycles(60);
        check("scan4_issue_count", cmp_seen, 4);
        bus_read(A_STAT, stat(0, 1, 0, 0, 2, 4));

        // abort after 3 issues, then stray hit results that must be ignored
        bus_write(A_LEN, 128'd8);
        hit_pat = '0;
        res_idx = 0;
        cmp_seen = 0;
        expect_scan(4, 3);
        bus_write(A_CTRL, 128'h1);
        for (i = 0; i < 300 && cmp_seen < 3; i++) begin
            @(posedge PicoClk); #2;
        end
        if (cmp_seen < 3) begin
            checks++; failures++;
            $display("FAIL abort_wait_timeout: got %0d issues expected 3", cmp_seen);
        end
        bus_write(A_CTRL, 128'h2);
        inj_cnt = 2;
        idle_cycles(20);
        bus_read(A_STAT, stat(0, 1, 1, 0, 0, 3));

        // restart after abort completes normally
        bus_write(A_LEN, 128'd2);
        hit_pat = 8'b0000_0001;
        res_idx = 0;
        cmp_seen = 0;
        expect_scan(2, 2);
        bus_write(A_CTRL, 128'h1);
        idle_cycles(40);
        bus_read(A_STAT, stat(0, 1, 0, 0, 1, 2));

        // writes while busy are ignored; second start ignored
        bus_write(A_LEN, 128'd3);
        hit_pat = '0;
        res_idx = 0;
        cmp_seen = 0;
        expect_scan(3, 3);
        bus_write(A_CTRL, 128'h1);
        bus_write(A_LEN, 128'd5);
        bus_write(A_QUERY, {16{8'h5A}});
        bus_write(A_CTRL, 128'h1);
        bus_read(A_LEN, 128'd3);
        bus_read(A_QUERY, cur_query);
        idle_cycles(60);
        check("busy_writes_issue_count", cmp_seen, 3);
        bus_read(A_STAT, stat(0, 1, 0, 0, 0, 3));

        // start+abort together while idle: abort only
        bus_write(A_CTRL, 128'h3);
        idle_cycles(10);
        bus_read(A_STAT, stat(0, 1, 1, 0, 0, 3));

        // completion interrupt (CTRL = start + irq enable)
        check("irq_none_before", irq_cnt, 0);
        bus_write(A_LEN, 128'd1);
        hit_pat = '0;
        res_idx = 0;
        expect_scan(1, 1);
        bus_write(A_CTRL, 128'h5);
        idle_cycles(30);
        check("irq_pulse_count", irq_cnt, IRQ_ON ? 1 : 0);
        check("irq_pulse_width", irq_long, 0);
        bus_read(A_STAT, stat(0, 1, 0, IRQ_ON, 0, 1));
        idle_cycles(4);

        check("fetch_queue_empty", exp_fetch.size(), 0);
        check("issue_queue_empty", exp_issue.size(), 0);
        check("read_queue_empty", exp_rd.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
